// File: rtl/ahrs_stream_pkg.sv
// Shared constants and types for the AHRS Xillybus read-pipe FIFOs.
package ahrs_stream_pkg;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CNT_W_DEF  = 16;

  // One read pipe per sample stream; the enum value doubles as the pipe index.
  typedef enum logic [3:0] {
    PIPE_ACC_X,
    PIPE_ACC_Y,
    PIPE_ACC_Z,
    PIPE_GYR_X,
    PIPE_GYR_Y,
    PIPE_GYR_Z,
    PIPE_MAG_X,
    PIPE_MAG_Y,
    PIPE_MAG_Z,
    PIPE_QUAT_W,
    PIPE_QUAT_X,
    PIPE_QUAT_Y,
    PIPE_QUAT_Z
  } ahrs_pipe_e;

  typedef enum logic [1:0] {
    ST_CLOSED,
    ST_STREAM,
    ST_DRAIN,
    ST_EOF
  } stream_state_e;

  // Stream state is implied by the open flag, pending EOF and emptiness.
  function automatic stream_state_e stream_state(input logic open, input logic eof_pend,
                                                 input logic empty);
    stream_state_e st;
    st = ST_CLOSED;
    if (open) begin
      if (!eof_pend)  st = ST_STREAM;
      else if (empty) st = ST_EOF;
      else            st = ST_DRAIN;
    end
    return st;
  endfunction

endpackage

// File: rtl/ahrs_sdp_ram.sv
// Simple dual-port RAM: synchronous write, registered read enabled per access.
module ahrs_sdp_ram #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Only the output register resets; array contents are don't-care.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ahrs_stream_fifo.sv
// One AHRS sample stream buffered into a Xillybus read pipe, with open/close
// gating, flush on close, saturating overflow-drop counter and end-of-file.
module ahrs_stream_fifo
  import ahrs_stream_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              bus_clk,
  input  logic              bus_rst,
  input  logic [DATA_W-1:0] smp_data,
  input  logic              smp_valid,
  input  logic              eof_req,
  input  logic              rd_open,
  input  logic              rd_rden,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_empty,
  output logic              rd_eof,
  output logic [ADDR_W:0]   level,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int unsigned DEPTH    = 2 ** ADDR_W;
  localparam int unsigned LVL_W    = ADDR_W + 1;
  localparam logic [ADDR_W:0] LVL_FULL = LVL_W'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              empty_q, empty_d;
  logic              eof_q, eof_d;
  logic              eof_pend_q, eof_pend_d;
  logic              open_q;
  logic [CNT_W-1:0]  drop_q, drop_d;

  logic open_rise, open_fall;
  logic rd_acc, wr_ok, wr_acc, drop_hit;

  // Accept/drop decisions and next-state for pointers, level and control.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    eof_pend_d = eof_pend_q;
    drop_d     = drop_q;

    open_rise = rd_open && !open_q;
    open_fall = !rd_open && open_q;
    rd_acc    = rd_rden && !empty_q && !open_fall;
    wr_ok     = smp_valid && rd_open && !eof_pend_q;
    wr_acc    = wr_ok && ((level_q != LVL_FULL) || rd_acc);
    drop_hit  = wr_ok && !wr_acc;

    if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_W'(1);

    unique case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // Word queued with a same-cycle eof_req is kept: the gate uses eof_pend_q.
    if (eof_req && rd_open) eof_pend_d = 1'b1;

    if (open_rise)                     drop_d = '0;
    else if (drop_hit && (drop_q != '1)) drop_d = drop_q + CNT_W'(1);

    if (open_fall) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      eof_pend_d = 1'b0;
    end

    empty_d = (level_d == '0);
    eof_d   = eof_pend_d && empty_d;
  end

  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      empty_q    <= 1'b1;
      eof_q      <= 1'b0;
      eof_pend_q <= 1'b0;
      open_q     <= 1'b0;
      drop_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      empty_q    <= empty_d;
      eof_q      <= eof_d;
      eof_pend_q <= eof_pend_d;
      open_q     <= rd_open;
      drop_q     <= drop_d;
    end
  end

  ahrs_sdp_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (bus_clk),
    .rst     (bus_rst),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (smp_data),
    .re_i    (rd_acc),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  assign rd_empty = empty_q;
  assign rd_eof   = eof_q;
  assign level    = level_q;
  assign drop_cnt = drop_q;

endmodule
